// File: rtl/ff_response_checker.sv
// Self-checking monitor for a single-bit D flip-flop: predicts q from the observed
// d/reset stimulus, compares the DUT response, and counts/classifies mismatches.
module ff_response_checker #(
  parameter int unsigned CNT_W         = 8,
  parameter bit          DUT_ASYNC_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic             clr,
  input  logic             dut_d,
  input  logic             dut_rst,
  input  logic             dut_q,
  input  logic             dut_qbar,
  output logic             exp_q,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic             err,
  output logic [1:0]       first_kind,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARM   = 2'b01,
    S_CHECK = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic             r_exp_q;
  logic             r_err_pulse;
  logic             r_err;
  logic [1:0]       r_first_kind;
  logic [CNT_W-1:0] r_check_count;
  logic [CNT_W-1:0] r_err_count;

  logic             w_model_upd;
  logic             w_compare;
  logic             w_exp_now;
  logic             w_q_fail;
  logic             w_qbar_fail;
  logic             w_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = chk_en ? S_ARM   : S_IDLE;
      S_ARM:   w_next = chk_en ? S_CHECK : S_IDLE;
      S_CHECK: w_next = chk_en ? S_CHECK : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // An asynchronous-reset DUT already shows q=0 at an edge where its reset is sampled high.
  always_comb begin
    w_model_upd = (r_state != S_IDLE);
    w_compare   = (r_state == S_CHECK) && chk_en;
    w_exp_now   = (DUT_ASYNC_RST && dut_rst) ? 1'b0 : r_exp_q;
    w_q_fail    = (dut_q != w_exp_now);
    w_qbar_fail = (dut_qbar == dut_q);
    w_mismatch  = w_q_fail || w_qbar_fail;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_exp_q <= 1'b0;
    else if (w_model_upd) r_exp_q <= dut_rst ? 1'b0 : dut_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse   <= 1'b0;
      r_err         <= 1'b0;
      r_first_kind  <= '0;
      r_check_count <= '0;
      r_err_count   <= '0;
    end else if (clr) begin
      r_err_pulse   <= 1'b0;
      r_err         <= 1'b0;
      r_first_kind  <= '0;
      r_check_count <= '0;
      r_err_count   <= '0;
    end else if (w_compare) begin
      r_err_pulse <= w_mismatch;
      if (r_check_count != CNT_MAX) r_check_count <= r_check_count + 1'b1;
      if (w_mismatch) begin
        r_err <= 1'b1;
        if (r_err_count != CNT_MAX) r_err_count <= r_err_count + 1'b1;
        if (!r_err) r_first_kind <= {w_qbar_fail, w_q_fail};
      end
    end else begin
      r_err_pulse <= 1'b0;
    end
  end

  assign exp_q       = r_exp_q;
  assign state       = r_state;
  assign err_pulse   = r_err_pulse;
  assign err         = r_err;
  assign first_kind  = r_first_kind;
  assign check_count = r_check_count;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_ff_response_checker.sv
// Bench for ff_response_checker: drives a synchronous and an asynchronous-reset-mode
// instance with the same stimulus and checks both against a run-length reference model.
module tb_ff_response_checker;

  logic       clk = 1'b0;
  logic       rst_n, chk_en, clr, dut_d, dut_rst, dut_q, dut_qbar;

  logic       s_exp_q, s_pulse, s_err;
  logic [1:0] s_state, s_kind;
  logic [7:0] s_cc, s_ec;

  logic       a_exp_q, a_pulse, a_err;
  logic [1:0] a_state, a_kind;
  logic [2:0] a_cc, a_ec;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: consecutive enabled edges, last sampled stimulus, per-instance flags.
  int         m_run;
  logic       prev_d, prev_rst;
  logic       m_exp   [2];
  logic       m_pulse [2];
  logic       m_err   [2];
  logic [1:0] m_kind  [2];
  int         m_cc    [2];
  int         m_ec    [2];
  logic       ff_q;

  ff_response_checker #(.CNT_W(8), .DUT_ASYNC_RST(1'b0)) u_sync (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr),
    .dut_d(dut_d), .dut_rst(dut_rst), .dut_q(dut_q), .dut_qbar(dut_qbar),
    .exp_q(s_exp_q), .state(s_state), .err_pulse(s_pulse), .err(s_err),
    .first_kind(s_kind), .check_count(s_cc), .err_count(s_ec)
  );

  ff_response_checker #(.CNT_W(3), .DUT_ASYNC_RST(1'b1)) u_async (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr),
    .dut_d(dut_d), .dut_rst(dut_rst), .dut_q(dut_q), .dut_qbar(dut_qbar),
    .exp_q(a_exp_q), .state(a_state), .err_pulse(a_pulse), .err(a_err),
    .first_kind(a_kind), .check_count(a_cc), .err_count(a_ec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0;
    for (int k = 0; k < 2; k++) begin
      m_exp[k] = 1'b0; m_pulse[k] = 1'b0; m_err[k] = 1'b0;
      m_kind[k] = 2'b00; m_cc[k] = 0; m_ec[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit   cmp;
    int   maxc;
    logic eq;
    bit   qf, bf;
    cmp = (m_run >= 2) && chk_en;
    for (int k = 0; k < 2; k++) begin
      maxc = (k == 0) ? 255 : 7;
      eq   = ((k == 1) && dut_rst) ? 1'b0 : (prev_rst ? 1'b0 : prev_d);
      qf   = (dut_q !== eq);
      bf   = (dut_qbar === dut_q);
      if (clr) begin
        m_pulse[k] = 1'b0; m_err[k] = 1'b0; m_kind[k] = 2'b00; m_cc[k] = 0; m_ec[k] = 0;
      end else if (cmp) begin
        m_pulse[k] = qf || bf;
        if (m_cc[k] < maxc) m_cc[k]++;
        if (qf || bf) begin
          if (m_ec[k] < maxc) m_ec[k]++;
          if (!m_err[k]) m_kind[k] = {bf, qf};
          m_err[k] = 1'b1;
        end
      end else begin
        m_pulse[k] = 1'b0;
      end
      if (m_run >= 1) m_exp[k] = dut_rst ? 1'b0 : dut_d;
    end
    m_run    = chk_en ? ((m_run >= 2) ? 2 : m_run + 1) : 0;
    prev_d   = dut_d;
    prev_rst = dut_rst;
  endtask

  task automatic check_all();
    logic [1:0] st;
    st = (m_run == 0) ? 2'b00 : (m_run == 1) ? 2'b01 : 2'b10;
    chk("s_exp_q", s_exp_q, m_exp[0]);
    chk("s_state", s_state, st);
    chk("s_err_pulse", s_pulse, m_pulse[0]);
    chk("s_err", s_err, m_err[0]);
    chk("s_first_kind", s_kind, m_kind[0]);
    chk("s_check_count", s_cc, m_cc[0]);
    chk("s_err_count", s_ec, m_ec[0]);
    chk("a_exp_q", a_exp_q, m_exp[1]);
    chk("a_state", a_state, st);
    chk("a_err_pulse", a_pulse, m_pulse[1]);
    chk("a_err", a_err, m_err[1]);
    chk("a_first_kind", a_kind, m_kind[1]);
    chk("a_check_count", a_cc, m_cc[1]);
    chk("a_err_count", a_ec, m_ec[1]);
  endtask

  task automatic step(input logic en, input logic cl, input logic d, input logic rst,
                      input logic q, input logic qb);
    chk_en = en; clr = cl; dut_d = d; dut_rst = rst; dut_q = q; dut_qbar = qb;
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    else       model_reset();
    ff_q = rst ? 1'b0 : d;
    check_all();
    @(negedge clk);
  endtask

  task automatic good(input logic en, input logic cl, input logic d, input logic rst);
    step(en, cl, d, rst, ff_q, ~ff_q);
  endtask

  task automatic qfault(input logic en, input logic cl, input logic d, input logic rst);
    step(en, cl, d, rst, ~ff_q, ff_q);
  endtask

  initial begin
    logic rq;
    rst_n = 1'b0; ff_q = 1'b0; prev_d = 1'b0; prev_rst = 1'b0;
    model_reset();

    // Reset with random inputs.
    for (int i = 0; i < 3; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    rst_n = 1'b1;

    // Clean stream after a DUT reset.
    good(1, 0, 0, 1);
    good(1, 0, 0, 1);
    good(1, 0, 1, 0);
    good(1, 0, 0, 0);
    good(1, 0, 1, 0);
    good(1, 0, 1, 0);
    good(1, 0, 0, 0);
    chk("clean_count", s_cc, 5);
    chk("clean_err", s_err, 0);
    chk("clean_err_count", s_ec, 0);

    // Single q fault while the previous d was 1.
    good(1, 0, 1, 0);
    qfault(1, 0, 0, 0);
    chk("qfault_pulse", s_pulse, 1);
    chk("qfault_err_count", s_ec, 1);
    chk("qfault_kind", s_kind, 2'b01);
    good(1, 0, 0, 0);
    chk("qfault_pulse_one_cycle", s_pulse, 0);

    // qbar fault twice then a q fault.
    good(1, 1, 1, 0);
    step(1, 0, 1, 0, ff_q, ff_q);
    step(1, 0, 1, 0, ff_q, ff_q);
    qfault(1, 0, 0, 0);
    chk("qbar_err_count", s_ec, 3);
    chk("qbar_kind", s_kind, 2'b10);

    // Reset priority over d.
    good(1, 1, 0, 0);
    good(1, 0, 1, 1);
    good(1, 0, 0, 0);
    chk("rstprio_ok", s_pulse, 0);
    good(1, 0, 1, 1);
    step(1, 0, 0, 0, 1'b1, 1'b0);
    chk("rstprio_qmis", s_pulse, 1);
    good(1, 0, 1, 0);
    step(1, 0, 1, 1, 1'b1, 1'b0);
    chk("async_rst_edge_flag", a_pulse, 1);
    chk("sync_rst_edge_ok", s_pulse, 0);

    // Saturation, clear, and freezing on disable.
    good(1, 1, 0, 0);
    for (int i = 0; i < 9; i++) qfault(1, 0, $urandom_range(0, 1), 0);
    chk("sat_err_count", a_ec, 7);
    chk("sat_check_count", a_cc, 7);
    chk("nosat_err_count", s_ec, 9);
    good(1, 1, 0, 0);
    chk("clr_check_count", a_cc, 0);
    chk("clr_err_count", a_ec, 0);
    chk("clr_err", a_err, 0);
    qfault(1, 0, 1, 0);
    qfault(1, 0, 0, 0);
    qfault(0, 0, 1, 0);
    chk("drop_state", s_state, 2'b00);
    qfault(0, 0, 0, 0);
    qfault(0, 0, 1, 0);
    chk("frozen_err_count", a_ec, 2);

    // Checker reset mid-check takes effect immediately.
    good(1, 0, 1, 0);
    good(1, 0, 0, 0);
    qfault(1, 0, 1, 0);
    qfault(1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    good(1, 0, 1, 0);
    rst_n = 1'b1;

    // Randomized stream.
    for (int i = 0; i < 400; i++) begin
      rq = ff_q ^ ($urandom_range(0, 6) == 0);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1),
           $urandom_range(0, 4) == 0, rq, (~rq) ^ ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ff_response_checker.md
# ff_response_checker

Synthesizable self-checking monitor for the single-bit D flip-flop blocks in this library. It observes the stimulus the flip-flop receives (d and its active-high reset) and the responses it produces (q, qbar). A cycle-accurate reference model predicts q, and the block flags, counts and classifies every mismatch. It sits alongside the flip-flop under test on the same clock and turns directed stimulus into a pass/fail verdict in hardware.

## Interface
Parameters:
- CNT_W, 8, width of the check and error counters (saturating).
- DUT_ASYNC_RST, 0, selects the observed flip-flop's reset style.
  - 0: the DUT reset is synchronous and takes effect at the sampling edge.
  - 1: the DUT reset is asynchronous and q is already 0 at an edge where it is sampled high.

Ports:
- clk  in  1  single clock; all checker state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset of the checker. Independent of the DUT reset.
- chk_en  in  1  enables checking; sampled on the rising edge.
- clr  in  1  synchronous clear of the counters, err and first_kind. Takes priority over counting that cycle.
- dut_d  in  1  d as driven to the DUT.
- dut_rst  in  1  active-high reset as driven to the DUT.
- dut_q  in  1  DUT q.
- dut_qbar  in  1  DUT qbar.
- exp_q  out  1  reference-model prediction of q.
- state  out  2  00 IDLE, 01 ARM, 10 CHECK.
- err_pulse  out  1  high for exactly one cycle per mismatching compare.
- err  out  1  sticky; set on the first mismatch.
- first_kind  out  2  classification of the first mismatch.
  - bit0: q is not equal to exp_q.
  - bit1: qbar is not the complement of q.
- check_count  out  CNT_W  number of compares performed.
- err_count  out  CNT_W  number of mismatching compares.

## Operation
- Reset (rst_n=0, asynchronous) forces every output to 0: state=IDLE, exp_q=0, err_pulse=0, err=0, first_kind=00, check_count=0, err_count=0.
- State machine, evaluated at each rising edge:
  - IDLE: if chk_en=1, go to ARM.
  - ARM: loads exp_q from the model and performs no compare. Goes to CHECK if chk_en=1, else IDLE.
  - CHECK: performs a compare, then updates exp_q. Goes to IDLE when chk_en=0. No compare is made on that edge.
- Model update, applied in ARM and CHECK at every edge:
  - exp_q ← 0 if dut_rst=1.
  - Otherwise exp_q ← dut_d.
- Compare, performed in CHECK at an edge using values sampled just before that edge:
  - The q check fails if dut_q differs from the exp_q register, which holds the prediction from the previous edge.
  - If DUT_ASYNC_RST=1 and dut_rst=1 at this edge, the expected q is 0 instead of the exp_q register.
  - The qbar check fails if dut_qbar equals dut_q.
  - A compare is a mismatch if either check fails.
- Counters and flags, updated on each compare:
  - check_count increments by 1.
  - On a mismatch: err_count increments, err_pulse=1 for that cycle, and err is set.
  - first_kind is loaded only if err was 0 before the mismatch.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- clr=1 at an edge:
  - Counters, err and first_kind go to 0, and err_pulse goes to 0.
  - The model and state still advance normally.
  - A compare on that edge is discarded.
- Dropping chk_en mid-stream freezes the counters and flags and returns to IDLE. Re-enabling requires a new ARM cycle.

## Timing
- Outputs are registered; no output depends combinationally on inputs.
- The checker expects DUT inputs to change away from the rising edge (negedge drive, as in the library benches). dut_q must settle before the next rising edge.
- Latency from the edge where a DUT value is captured to the compare of that value: 1 cycle. err_pulse and the counters reflect the compare from the edge that produced them.
- First compare: the second rising edge after chk_en is first sampled high.
- DUT reset asserted and deasserted between edges: only values sampled at edges matter. Pulses shorter than a cycle are not modeled.
- Simultaneous dut_rst=1 and dut_d=1 at an edge: reset wins and exp_q=0.
- rst_n asserted mid-check: immediate return to reset values with no partial update.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs -> every output is 0 and state=00.
- Clean stream: enable, feed a correct DUT with d=1,0,1,1,0 after a DUT reset -> check_count=5 after 5 compares, err=0, err_count=0.
- q fault: force dut_q=0 while the previous d=1, for one cycle -> err_pulse high for exactly 1 cycle, err=1, first_kind=01, err_count=1.
- qbar fault: tie dut_qbar=dut_q for 2 cycles, then a q fault -> err_count=3 and first_kind stays 10.
- Reset priority: dut_rst=1 with dut_d=1 at an edge, DUT q=0 next cycle -> no error. Repeat with DUT q=1 -> q mismatch. With DUT_ASYNC_RST=1 and q=1 on the reset edge itself -> error flagged on that edge.
- Saturation and clear: CNT_W=3, inject 9 faults -> err_count=7 and check_count=7 (saturated). Pulse clr -> all counters 0 and err=0. Drop chk_en -> state returns to 00 and the counters freeze.
